// File: rtl/alu_pipe_if.sv
// alu_pipe_if: bundles the action/operand request and the result/status response
// of alu_pipe.
//   master : drives action_in, action_valid, operand_1_in, operand_2_in;
//            observes container_out, container_out_valid, ovf_out, inflight_cnt
//   slave  : the ALU side of the same signals
interface alu_pipe_if #(
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 48
);
    logic [ACTION_LEN-1:0] action_in;
    logic                  action_valid;
    logic [DATA_WIDTH-1:0] operand_1_in;
    logic [DATA_WIDTH-1:0] operand_2_in;
    logic [DATA_WIDTH-1:0] container_out;
    logic                  container_out_valid;
    logic                  ovf_out;
    logic [4:0]            inflight_cnt;

    modport master (
        output action_in, action_valid, operand_1_in, operand_2_in,
        input  container_out, container_out_valid, ovf_out, inflight_cnt
    );

    modport slave (
        input  action_in, action_valid, operand_1_in, operand_2_in,
        output container_out, container_out_valid, ovf_out, inflight_cnt
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: fully pipelined ALU stage. The result is computed in the cycle an
// action is accepted and then delayed so that it appears LATENCY cycles later,
// in order, with no back-pressure.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   alu  : alu_pipe_if.slave (action_in/action_valid/operand_1_in/operand_2_in in,
//          container_out/container_out_valid/ovf_out/inflight_cnt out)
// Parameters: STAGE_ID (informational), ACTION_LEN (25), DATA_WIDTH (16..64),
//             LATENCY (1..16).
// Configuration macro: ALU_SATURATE_EN -- overflowing add yields all-ones and
// underflowing sub yields zero (ovf_out still set); otherwise results wrap.
module alu_pipe #(
    parameter int STAGE_ID   = 0,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 48,
    parameter int LATENCY    = 5
) (
    input  logic     clk,
    input  logic     rst,
    alu_pipe_if.slave alu
);
    logic [3:0]            w_opcode;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [DATA_WIDTH-1:0] w_rhs;
    logic                  w_is_add;
    logic                  w_is_sub;
    logic                  w_sel_op2;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_ovf;
    logic                  w_inc;
    logic                  w_dec;
    logic                  w_unused;

    logic [DATA_WIDTH-1:0] r_data [LATENCY];
    logic [LATENCY-1:0]    r_ovf;
    logic [LATENCY-1:0]    r_vld;
    logic [4:0]            r_cnt;

    assign w_opcode = alu.action_in[ACTION_LEN-1 -: 4];
    assign w_unused = ^{alu.action_in[20:16], 32'(STAGE_ID)};

    always_comb begin
        w_imm       = '0;
        w_imm[15:0] = alu.action_in[15:0];
        w_rhs       = alu.operand_2_in;
        w_is_add    = 1'b0;
        w_is_sub    = 1'b0;
        w_sel_op2   = 1'b0;
        unique case (w_opcode)
            4'b0001, 4'b1001: w_is_add = 1'b1;
            4'b0010, 4'b1010: w_is_sub = 1'b1;
            4'b0011: begin
                w_is_add = 1'b1;
                w_rhs    = w_imm;
            end
            4'b0100: begin
                w_is_sub = 1'b1;
                w_rhs    = w_imm;
            end
            4'b1110: w_sel_op2 = 1'b1;
            default: ;
        endcase
    end

    // Extra top bit carries the add carry-out / sub borrow.
    assign w_sum  = {1'b0, alu.operand_1_in} + {1'b0, w_rhs};
    assign w_diff = {1'b0, alu.operand_1_in} - {1'b0, w_rhs};

    always_comb begin
        w_result = alu.operand_1_in;
        w_ovf    = 1'b0;
        if (w_is_add) begin
            w_result = w_sum[DATA_WIDTH-1:0];
            w_ovf    = w_sum[DATA_WIDTH];
`ifdef ALU_SATURATE_EN
            if (w_sum[DATA_WIDTH]) w_result = '1;
`endif
        end else if (w_is_sub) begin
            w_result = w_diff[DATA_WIDTH-1:0];
            w_ovf    = w_diff[DATA_WIDTH];
`ifdef ALU_SATURATE_EN
            if (w_diff[DATA_WIDTH]) w_result = '0;
`endif
        end else if (w_sel_op2) begin
            w_result = alu.operand_2_in;
        end
    end

    // Valid bits shift every cycle; data/ovf only load behind a valid bit, so
    // the final stage naturally holds the last valid result between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_ovf <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) r_data[i] <= '0;
        end else begin
            r_vld[0] <= alu.action_valid;
            if (alu.action_valid) begin
                r_data[0] <= w_result;
                r_ovf[0]  <= w_ovf;
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_data[i] <= r_data[i-1];
                    r_ovf[i]  <= r_ovf[i-1];
                end
            end
        end
    end

    // An operation stops counting as in flight once it moves into the output
    // register, so the count tops out at LATENCY-1.
    assign w_inc = alu.action_valid;
    generate
        if (LATENCY == 1) begin : g_dec_direct
            assign w_dec = alu.action_valid;
        end else begin : g_dec_stage
            assign w_dec = r_vld[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= r_cnt + {4'b0, w_inc} - {4'b0, w_dec};
    end

    assign alu.container_out       = r_data[LATENCY-1];
    assign alu.container_out_valid = r_vld[LATENCY-1];
    assign alu.ovf_out             = r_ovf[LATENCY-1];
    assign alu.inflight_cnt        = r_cnt;
endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    localparam int DW  = 48;
    localparam int LAT = 5;
    localparam logic [63:0] MOD = 64'h0001_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_pipe_if #(.ACTION_LEN(25), .DATA_WIDTH(DW)) bus ();

    alu_pipe #(
        .STAGE_ID(0), .ACTION_LEN(25), .DATA_WIDTH(DW), .LATENCY(LAT)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .alu(bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int last_acc;

    typedef struct {
        int          due;
        logic [63:0] d;
        bit          o;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Behavioural reference: plain 64-bit arithmetic against the 2^48 modulus.
    function automatic void model(input logic [3:0] op, input logic [15:0] imm,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output bit o);
        logic [63:0] rhs;
        bit          add, sub;
        rhs = b; add = 0; sub = 0; o = 0; r = a;
        case (op)
            4'd1, 4'd9:  add = 1;
            4'd2, 4'd10: sub = 1;
            4'd3: begin add = 1; rhs = 64'(imm); end
            4'd4: begin sub = 1; rhs = 64'(imm); end
            4'd14: r = b;
            default: r = a;
        endcase
        if (add) begin
            r = a + rhs;
            o = (r >= MOD);
`ifdef ALU_SATURATE_EN
            if (o) r = MOD - 64'd1;
`else
            if (o) r = r - MOD;
`endif
        end else if (sub) begin
            o = (a < rhs);
`ifdef ALU_SATURATE_EN
            r = o ? 64'd0 : a - rhs;
`else
            r = o ? MOD + a - rhs : a - rhs;
`endif
        end
    endfunction

    always @(posedge clk) begin
        logic [63:0] r;
        bit          o;
        if (!rst && bus.action_valid) begin
            model(bus.action_in[24:21], bus.action_in[15:0],
                  64'(bus.operand_1_in), 64'(bus.operand_2_in), r, o);
            q.push_back('{due: cyc + LAT, d: r, o: o});
        end
        cyc++;
    end

    logic [63:0] held_d = '0;
    bit          held_o = 0;

    always @(negedge clk) begin
        bit exp_v;
        exp_v = 0;
        if (rst) begin
            q.delete();
            held_d = '0;
            held_o = 0;
        end else if (q.size() > 0 && q[0].due == cyc) begin
            exp_v  = 1;
            held_d = q[0].d;
            held_o = q[0].o;
            void'(q.pop_front());
        end
        check("mdl_valid", 64'(bus.container_out_valid), 64'(exp_v));
        check("mdl_data",  64'(bus.container_out), held_d);
        check("mdl_ovf",   64'(bus.ovf_out), 64'(held_o));
        check("mdl_inflight", 64'(bus.inflight_cnt), 64'(q.size()));
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] imm,
                         input logic [47:0] a, input logic [47:0] b);
        @(posedge clk); #1;
        bus.action_in    = {op, 5'b0, imm};
        bus.action_valid = 1'b1;
        bus.operand_1_in = a;
        bus.operand_2_in = b;
        last_acc = cyc;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.action_valid = 1'b0;
        bus.operand_1_in = 48'h5A5A_0000_A5A5;
        bus.operand_2_in = 48'h0000_1234_0000;
    endtask

    task automatic expect_out(input string name, input int acc,
                              input logic [47:0] d, input bit o);
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.container_out_valid && waited < 40);
        check({name, "_valid"}, 64'(bus.container_out_valid), 64'd1);
        check({name, "_latency"}, 64'(cyc - acc), 64'(LAT));
        check({name, "_data"}, 64'(bus.container_out), 64'(d));
        check({name, "_ovf"}, 64'(bus.ovf_out), 64'(o));
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] imm;
        logic [47:0] a;
        logic [47:0] b;
    } vec_t;

    vec_t vecs[] = '{
        '{4'b1001, 16'h0000, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0000},
        '{4'b1001, 16'h0000, 48'h8000_0000_0000, 48'h8000_0000_0001},
        '{4'b1010, 16'h0000, 48'h0000_0000_0001, 48'h0000_0000_0002},
        '{4'b0010, 16'h0000, 48'h1234_5678_9ABC, 48'h1234_5678_9ABC},
        '{4'b0011, 16'hFFFF, 48'hFFFF_FFFF_0000, 48'h0000_0000_0007},
        '{4'b0011, 16'hFFFF, 48'hFFFF_FFFF_0001, 48'h0000_0000_0007},
        '{4'b0100, 16'h0010, 48'h0000_0000_0010, 48'h0000_0000_0000},
        '{4'b0000, 16'h1111, 48'hDEAD_BEEF_0001, 48'h0000_0000_0002},
        '{4'b1111, 16'h2222, 48'hCAFE_0000_0003, 48'h0000_0000_0004},
        '{4'b1110, 16'h3333, 48'h0000_0000_0005, 48'hFEDC_BA98_7654}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int pulses;
        rst = 1'b1;
        bus.action_in    = '0;
        bus.action_valid = 1'b0;
        bus.operand_1_in = '0;
        bus.operand_2_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data",     64'(bus.container_out), 64'd0);
        check("rst_valid",    64'(bus.container_out_valid), 64'd0);
        check("rst_ovf",      64'(bus.ovf_out), 64'd0);
        check("rst_inflight", 64'(bus.inflight_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic add, 5-cycle latency.
        issue(4'b0001, 16'h0, 48'd10, 48'd5);
        a0 = last_acc;
        idle();
        expect_out("add_basic", a0, 48'd15, 1'b0);

        // Back-to-back mixed ops come out on consecutive cycles.
        issue(4'b0001, 16'h0,   48'h20, 48'h8);
        a0 = last_acc;
        issue(4'b0010, 16'h0,   48'h20, 48'h8);
        issue(4'b0011, 16'h100, 48'h20, 48'h8);
        issue(4'b1110, 16'h0,   48'h20, 48'h8);
        idle();
        expect_out("b2b0", a0, 48'h28, 1'b0);
        @(negedge clk);
        check("b2b1_valid", 64'(bus.container_out_valid), 64'd1);
        check("b2b1_data",  64'(bus.container_out), 64'h18);
        @(negedge clk);
        check("b2b2_valid", 64'(bus.container_out_valid), 64'd1);
        check("b2b2_data",  64'(bus.container_out), 64'h120);
        @(negedge clk);
        check("b2b3_valid", 64'(bus.container_out_valid), 64'd1);
        check("b2b3_data",  64'(bus.container_out), 64'h8);
        @(negedge clk);
        check("hold_valid", 64'(bus.container_out_valid), 64'd0);
        check("hold_data",  64'(bus.container_out), 64'h8);

        // Add overflow and sub-immediate underflow.
        issue(4'b0001, 16'h0, 48'hFFFF_FFFF_FFFF, 48'd2);
        a0 = last_acc;
        idle();
`ifdef ALU_SATURATE_EN
        expect_out("add_ovf", a0, 48'hFFFF_FFFF_FFFF, 1'b1);
`else
        expect_out("add_ovf", a0, 48'h0000_0000_0001, 1'b1);
`endif
        issue(4'b0100, 16'd5, 48'd3, 48'd0);
        a0 = last_acc;
        idle();
`ifdef ALU_SATURATE_EN
        expect_out("sub_unf", a0, 48'h0, 1'b1);
`else
        expect_out("sub_unf", a0, 48'hFFFF_FFFF_FFFE, 1'b1);
`endif

        // Pass-through and in-flight count profile.
        issue(4'b0111, 16'h0, 48'hABC, 48'h999);
        a0 = last_acc;
        idle();
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check("pass_inflight", 64'(bus.inflight_cnt), (k < LAT) ? 64'd1 : 64'd0);
        end
        check("pass_valid", 64'(bus.container_out_valid), 64'd1);
        check("pass_data",  64'(bus.container_out), 64'hABC);
        check("pass_ovf",   64'(bus.ovf_out), 64'd0);

        // Directed vector table, issued back-to-back; checked by the model.
        foreach (vecs[i]) issue(vecs[i].op, vecs[i].imm, vecs[i].a, vecs[i].b);
        @(negedge clk);
        check("full_inflight", 64'(bus.inflight_cnt), 64'(LAT - 1));
        idle();
        repeat (LAT + 2) @(posedge clk);

        // Reset while operations are in flight discards them.
        issue(4'b0001, 16'h0, 48'd1, 48'd1);
        issue(4'b0001, 16'h0, 48'd2, 48'd2);
        issue(4'b0001, 16'h0, 48'd3, 48'd3);
        idle();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.container_out_valid) pulses++;
        end
        check("rst_flush_pulses",   64'(pulses), 64'd0);
        check("rst_flush_inflight", 64'(bus.inflight_cnt), 64'd0);
        issue(4'b0010, 16'h0, 48'd100, 48'd1);
        a0 = last_acc;
        idle();
        expect_out("post_rst", a0, 48'd99, 1'b0);

        repeat (LAT + 2) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter STAGE_ID, default 0: pipeline stage index, informational only, no functional effect.
REQ-002 Parameter ACTION_LEN, default 25: action word width; legal value 25 only.
REQ-003 Parameter DATA_WIDTH, default 48: operand and result width; legal range 16..64.
REQ-004 Parameter LATENCY, default 5: cycles from accepted input to valid output; legal range 1..16.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 action_in  input  ACTION_LEN  opcode in [24:21], immediate in [15:0].
REQ-008 action_valid  input  1  qualifies action_in and both operands for one cycle.
REQ-009 operand_1_in  input  DATA_WIDTH  first operand, from the PHV container.
REQ-010 operand_2_in  input  DATA_WIDTH  second operand, from the PHV container.
REQ-011 container_out  output  DATA_WIDTH  registered result.
REQ-012 container_out_valid  output  1  one-cycle pulse qualifying container_out.
REQ-013 ovf_out  output  1  overflow/underflow flag, aligned with container_out_valid.
REQ-014 inflight_cnt  output  5  number of accepted operations not yet output.

Function
REQ-015 Fully pipelined: the block accepts an operation on every cycle that action_valid=1, with no back-pressure.
REQ-016 Each accepted operation produces exactly one container_out_valid pulse exactly LATENCY cycles after acceptance; input order is preserved.
REQ-017 Opcode 0001 or 1001 = op1+op2; 0010 or 1010 = op1-op2.
REQ-018 Opcode 0011 = op1+imm; 0100 = op1-imm; imm is action_in[15:0] zero-extended to DATA_WIDTH.
REQ-019 Opcode 1110 = op2; every other opcode = op1 (pass-through).
REQ-020 Arithmetic is unsigned modulo 2^DATA_WIDTH unless REQ-029 applies.
REQ-021 ovf_out=1 on carry-out of add or borrow of sub; otherwise 0.
REQ-022 The result is computed in the acceptance cycle; stages 2..LATENCY only delay it.
REQ-023 When container_out_valid=0, container_out and ovf_out hold their last valid values; they are not zeroed.
REQ-024 inflight_cnt increments on acceptance and decrements on output; simultaneous accept and output leaves it unchanged.
REQ-025 inflight_cnt never exceeds LATENCY.
REQ-026 With LATENCY=1, output is registered one cycle after acceptance; back-to-back inputs produce back-to-back outputs.

Reset
REQ-027 While rst=1: container_out=0, ovf_out=0, container_out_valid=0, inflight_cnt=0, and all pipeline valid bits are 0.
REQ-028 Operations in flight when rst asserts are discarded and never produce output; the first input accepted after rst deasserts is processed normally.

Configuration
REQ-029 Macro ALU_SATURATE_EN: when defined, an add that overflows yields all-ones and a sub that underflows yields 0, with ovf_out still 1; when undefined, wrap-around per REQ-020.

Verification
REQ-030 LATENCY=5, DW=48: op 0001, op1=10, op2=5 at cycle 0 -> container_out=15, valid at cycle 5, ovf_out=0.
REQ-031 Four back-to-back ops 0001, 0010, 0011 imm=0x100, 1110 with op1=0x20, op2=0x8 -> outputs 0x28, 0x18, 0x120, 0x8 on four consecutive cycles.
REQ-032 op 0001, op1=0xFFFF_FFFF_FFFF, op2=2 -> without macro: 1, ovf=1; with ALU_SATURATE_EN: 0xFFFF_FFFF_FFFF, ovf=1.
REQ-033 op 0100, op1=3, imm=5 -> without macro: 0xFFFF_FFFF_FFFE, ovf=1; with macro: 0, ovf=1.
REQ-034 Three ops accepted, then rst pulsed for 1 cycle two cycles later -> no valid pulses, inflight_cnt=0; a new op after reset outputs after LATENCY cycles.
REQ-035 Opcode 0111, op1=0xABC -> output 0xABC, ovf=0; inflight_cnt reads 1 through LATENCY-1 cycles, then 0.
